// File: rtl/shift_seq_ctrl_if.sv
// Command and shift-register control bundle for shift_seq_ctrl.
// The master side issues commands. The slave side drives the shift register controls.
interface shift_seq_ctrl_if #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_clear;
   logic          cmd_dir;
   logic [CW-1:0] cmd_count;
   logic [N-1:0]  cmd_data;
   logic          abort;
   logic          sr_clr;
   logic          sr_en;
   logic          sr_dir;
   logic          sr_din;
   logic          busy;
   logic          done;
   logic          aborted;

   modport master (
      output cmd_valid, cmd_clear, cmd_dir, cmd_count, cmd_data, abort,
      input  cmd_ready, sr_clr, sr_en, sr_dir, sr_din, busy, done, aborted
   );

   modport slave (
      input  cmd_valid, cmd_clear, cmd_dir, cmd_count, cmd_data, abort,
      output cmd_ready, sr_clr, sr_en, sr_dir, sr_din, busy, done, aborted
   );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer for an N-bit left/right shift register.
// It accepts one command at a time and feeds the register one serial bit per cycle, LSB first.
module shift_seq_ctrl #(
   parameter int N  = 4,
   parameter int CW = $clog2(N + 1)
) (
   input logic              clk,
   input logic              rst,
   shift_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state, state_next;
   logic [N-1:0]  data_reg, data_next;
   logic [CW-1:0] rem, rem_next;
   logic          dir_reg, dir_next;
   logic          aborted_reg, aborted_next;
   logic          accept;
   logic [CW-1:0] count_sat;

   assign accept    = bus.cmd_valid && (state == IDLE);
   assign count_sat = (bus.cmd_count > CW'(N)) ? CW'(N) : bus.cmd_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         data_reg    <= '0;
         rem         <= '0;
         dir_reg     <= 1'b0;
         aborted_reg <= 1'b0;
      end else begin
         state       <= state_next;
         data_reg    <= data_next;
         rem         <= rem_next;
         dir_reg     <= dir_next;
         aborted_reg <= aborted_next;
      end
   end

   // A shift in progress always completes its current cycle; abort only prevents the next one.
   always_comb begin
      state_next   = state;
      data_next    = data_reg;
      rem_next     = rem;
      dir_next     = dir_reg;
      aborted_next = aborted_reg;
      case (state)
         IDLE: begin
            if (accept) begin
               dir_next     = bus.cmd_dir;
               data_next    = bus.cmd_data;
               rem_next     = count_sat;
               aborted_next = 1'b0;
               if (bus.cmd_clear)
                  state_next = CLEAR;
               else if (count_sat == '0)
                  state_next = DONE;
               else
                  state_next = SHIFT;
            end
         end
         CLEAR: state_next = DONE;
         SHIFT: begin
            data_next = data_reg >> 1;
            rem_next  = rem - CW'(1);
            if (bus.abort) begin
               aborted_next = 1'b1;
               state_next   = DONE;
            end else if (rem == CW'(1)) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs depend only on state and registers, so command inputs never reach the register controls combinationally.
   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.sr_clr    = (state == CLEAR);
   assign bus.sr_en     = (state == SHIFT);
   assign bus.sr_dir    = (state == SHIFT) ? dir_reg : 1'b0;
   assign bus.sr_din    = (state == SHIFT) ? data_reg[0] : 1'b0;
   assign bus.done      = (state == DONE);
   assign bus.aborted   = aborted_reg;

   a_clr_en_exclusive: assert property (@(posedge clk) disable iff (rst) !(bus.sr_en && bus.sr_clr));

endmodule
